// File: rtl/ex_alu_stage_if.sv
// Handshake bundle for ex_alu_stage: ID/EX operation input side and EX/MEM result output side.
// slave = the ALU stage itself, master = the upstream/downstream environment driving it.
interface ex_alu_stage_if #(
  parameter int WIDTH = 32
);
  // Strict valid/ready on both sides: a transfer happens on a rising edge where
  // valid && ready; once valid is raised, the offering side holds payload and
  // valid stable until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       alu_conf;
  logic             sign;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       shamt;
  logic [4:0]       rd_in;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [4:0]       rd_out;
  logic             illegal;
  logic             ovf;

  modport slave (
    input  in_valid, alu_conf, sign, op_a, op_b, shamt, rd_in, out_ready,
    output in_ready, out_valid, result, zero, rd_out, illegal, ovf
  );

  modport master (
    output in_valid, alu_conf, sign, op_a, op_b, shamt, rd_in, out_ready,
    input  in_ready, out_valid, result, zero, rd_out, illegal, ovf
  );
endinterface

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU feeding a 2-entry skid buffer (EMPTY/ONE/FULL) with registered in_ready.
// Optional macro ALU_OVF_TRAP_EN: signed add/sub overflow sets ovf and zeroes rd_out.
module ex_alu_stage #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  ex_alu_stage_if.slave  bus,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [4:0]       rd;
    logic             illegal;
    logic             ovf;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, tail_q;
  entry_t new_entry;

  logic             in_ready_int;
  logic             out_valid_int;
  logic             accept;
  logic             pop;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             lt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             alu_ovf;

  assign sum  = bus.op_a + bus.op_b;
  assign diff = bus.op_a - bus.op_b;

`ifdef ALU_OVF_TRAP_EN
  // Signed overflow: operands agree in sign (add) / differ (sub) but result sign flips.
  assign add_ovf = bus.sign && (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1])
                            && (sum[WIDTH-1]  != bus.op_a[WIDTH-1]);
  assign sub_ovf = bus.sign && (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1])
                            && (diff[WIDTH-1] != bus.op_a[WIDTH-1]);
`else
  assign add_ovf = 1'b0;
  assign sub_ovf = 1'b0;
`endif

  assign lt = bus.sign ? ($signed(bus.op_a) < $signed(bus.op_b))
                       : (bus.op_a < bus.op_b);

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    alu_ovf = 1'b0;
    case (bus.alu_conf)
      5'd0: begin alu_res = sum;  alu_ovf = add_ovf; end
      5'd1: begin alu_res = diff; alu_ovf = sub_ovf; end
      5'd2: alu_res = bus.op_a & bus.op_b;
      5'd3: alu_res = bus.op_a | bus.op_b;
      5'd4: alu_res = bus.op_a ^ bus.op_b;
      5'd5: alu_res = ~(bus.op_a | bus.op_b);
      5'd6: alu_res = bus.op_b << bus.shamt;
      5'd7: alu_res = bus.op_b >> bus.shamt;
      5'd8: alu_res = $unsigned($signed(bus.op_b) >>> bus.shamt);
      5'd9: alu_res = {{(WIDTH-1){1'b0}}, lt};
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    new_entry.result  = alu_res;
    new_entry.zero    = (alu_res == '0);
    new_entry.rd      = alu_ovf ? 5'd0 : bus.rd_in;
    new_entry.illegal = alu_ill;
    new_entry.ovf     = alu_ovf;
  end

  assign accept = bus.in_valid && in_ready_int;
  assign pop    = out_valid_int && bus.out_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // FSM: next state; flush wins over any accept or pop in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_ONE;
      S_ONE: begin
        if (accept && !pop)      state_d = S_FULL;
        else if (pop && !accept) state_d = S_EMPTY;
      end
      S_FULL:  if (pop) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  // FSM: outputs decoded purely from the state register
  always_comb begin
    in_ready_int  = (state_q != S_FULL);
    out_valid_int = (state_q != S_EMPTY);
    dbg_state     = state_q;
  end

  // Entry storage: head is always what the outputs show, tail only holds the skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) head_q <= new_entry;
        S_ONE: begin
          if (accept && pop) head_q <= new_entry;
          else if (accept)   tail_q <= new_entry;
          else if (pop)      head_q <= '0;
        end
        S_FULL: begin
          if (pop) begin
            head_q <= tail_q;
            tail_q <= '0;
          end
        end
        default: begin
          head_q <= '0;
          tail_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = in_ready_int;
    bus.out_valid = out_valid_int;
    bus.result    = out_valid_int ? head_q.result  : '0;
    bus.zero      = out_valid_int ? head_q.zero    : 1'b0;
    bus.rd_out    = out_valid_int ? head_q.rd      : 5'd0;
    bus.illegal   = out_valid_int ? head_q.illegal : 1'b0;
    bus.ovf       = out_valid_int ? head_q.ovf     : 1'b0;
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed testbench for ex_alu_stage: ALU ops, skid backpressure, flush, overflow, async reset.
// Expected values are hand-computed; the ovf/rd_out checks follow ALU_OVF_TRAP_EN.
module tb_ex_alu_stage;

  localparam int WIDTH = 32;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  ex_alu_stage_if #(.WIDTH(WIDTH)) bus ();

  ex_alu_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] conf, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.alu_conf = conf;
    bus.sign     = sgn;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.shamt    = sh;
    bus.rd_in    = rd;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.alu_conf = 5'd31;
    bus.sign     = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.shamt    = '0;
    bus.rd_in    = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] res, input logic z,
                            input logic [4:0] rd);
    check({tag, "_valid"},  {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_result"}, bus.result, res);
    check({tag, "_zero"},   {31'd0, bus.zero}, {31'd0, z});
    check({tag, "_rd"},     {27'd0, bus.rd_out}, {27'd0, rd});
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"},    {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_result"},   bus.result, 32'd0);
    check({tag, "_zero"},     {31'd0, bus.zero}, 32'd0);
  endtask

  logic [4:0] exp_ovf_rd;
  logic       exp_ovf;

  initial begin
`ifdef ALU_OVF_TRAP_EN
    exp_ovf_rd = 5'd0;
    exp_ovf    = 1'b1;
`else
    exp_ovf_rd = 5'd9;
    exp_ovf    = 1'b0;
`endif
    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    #1;
    check_empty("reset");
    check("reset_rd",      {27'd0, bus.rd_out}, 32'd0);
    check("reset_illegal", {31'd0, bus.illegal}, 32'd0);
    check("reset_ovf",     {31'd0, bus.ovf}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single add, then back-to-back ops with out_ready high
    drive(5'd0, 1'b0, 32'd5, 32'd7, 5'd0, 5'd3);
    tick();
    check_head("add", 32'd12, 1'b0, 5'd3);
    drive(5'd9, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd4);
    tick();
    check_head("slt_s", 32'd1, 1'b0, 5'd4);
    drive(5'd9, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd5);
    tick();
    check_head("slt_u", 32'd0, 1'b1, 5'd5);
    drive(5'd8, 1'b0, 32'd0, 32'h8000_0000, 5'd4, 5'd6);
    tick();
    check_head("sra", 32'hF800_0000, 1'b0, 5'd6);
    drive(5'd7, 1'b0, 32'd0, 32'h8000_0000, 5'd4, 5'd7);
    tick();
    check_head("srl", 32'h0800_0000, 1'b0, 5'd7);
    drive(5'd6, 1'b0, 32'd0, 32'h0000_0003, 5'd31, 5'd8);
    tick();
    check_head("sll", 32'h8000_0000, 1'b0, 5'd8);
    drive(5'd1, 1'b0, 32'd3, 32'd5, 5'd0, 5'd10);
    tick();
    check_head("sub", 32'hFFFF_FFFE, 1'b0, 5'd10);
    drive(5'd1, 1'b0, 32'd5, 32'd5, 5'd0, 5'd11);
    tick();
    check_head("sub_zero", 32'd0, 1'b1, 5'd11);
    drive(5'd4, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 5'd12);
    tick();
    check_head("xor", 32'hF00F_F00F, 1'b0, 5'd12);
    drive(5'd5, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 5'd13);
    tick();
    check_head("nor", 32'h00F0_00F0, 1'b0, 5'd13);
    drive(5'd31, 1'b0, 32'd1, 32'd2, 5'd0, 5'd14);
    tick();
    check_head("illegal", 32'd0, 1'b1, 5'd14);
    check("illegal_flag", {31'd0, bus.illegal}, 32'd1);
    idle();
    tick();
    check_empty("drained");

    // backpressure: two accepted, third held off until the buffer drains
    bus.out_ready = 1'b0;
    drive(5'd0, 1'b0, 32'd1, 32'd1, 5'd0, 5'd1);
    tick();
    check_head("bp_a", 32'd2, 1'b0, 5'd1);
    check("bp_a_in_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(5'd3, 1'b0, 32'hF0, 32'h0F, 5'd0, 5'd2);
    tick();
    check_head("bp_full", 32'd2, 1'b0, 5'd1);
    check("bp_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    drive(5'd2, 1'b0, 32'hFF, 32'h0F, 5'd0, 5'd4);
    tick();
    check_head("bp_hold1", 32'd2, 1'b0, 5'd1);
    tick();
    check_head("bp_hold2", 32'd2, 1'b0, 5'd1);
    check("bp_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check_head("bp_b", 32'hFF, 1'b0, 5'd2);
    check("bp_b_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    check_head("bp_c", 32'h0F, 1'b0, 5'd4);
    idle();
    tick();
    check_empty("bp_done");

    // flush while FULL with an op offered
    bus.out_ready = 1'b0;
    drive(5'd0, 1'b0, 32'd100, 32'd1, 5'd0, 5'd20);
    tick();
    drive(5'd0, 1'b0, 32'd200, 32'd1, 5'd0, 5'd21);
    tick();
    check("fl_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    drive(5'd0, 1'b0, 32'd300, 32'd1, 5'd0, 5'd22);
    flush = 1'b1;
    tick();
    check_empty("flush_full");
    // flush with an accept in EMPTY also drops the op
    tick();
    check_empty("flush_empty");
    flush = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    tick();
    check_empty("flush_after");

    // overflow handling
    drive(5'd0, 1'b1, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd9);
    tick();
    check_head("ovf_add", 32'h8000_0000, 1'b0, exp_ovf_rd);
    check("ovf_add_flag", {31'd0, bus.ovf}, {31'd0, exp_ovf});
    drive(5'd0, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd9);
    tick();
    check_head("ovf_add_u", 32'h8000_0000, 1'b0, 5'd9);
    check("ovf_add_u_flag", {31'd0, bus.ovf}, 32'd0);
    drive(5'd1, 1'b1, 32'h8000_0000, 32'd1, 5'd0, 5'd9);
    tick();
    check_head("ovf_sub", 32'h7FFF_FFFF, 1'b0, exp_ovf_rd);
    check("ovf_sub_flag", {31'd0, bus.ovf}, {31'd0, exp_ovf});
    drive(5'd0, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd9);
    tick();
    check_head("no_ovf_add", 32'd0, 1'b1, 5'd9);
    check("no_ovf_add_flag", {31'd0, bus.ovf}, 32'd0);
    idle();
    tick();

    // asynchronous reset while FULL
    bus.out_ready = 1'b0;
    drive(5'd0, 1'b0, 32'd1, 32'd2, 5'd0, 5'd1);
    tick();
    drive(5'd0, 1'b0, 32'd3, 32'd4, 5'd0, 5'd2);
    tick();
    idle();
    check("ar_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    check("ar_pre_in_ready", {31'd0, bus.in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_empty("async_rst");
    check("async_rst_rd", {27'd0, bus.rd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(5'd0, 1'b0, 32'd10, 32'd20, 5'd0, 5'd5);
    tick();
    check_head("resume", 32'd30, 1'b0, 5'd5);
    idle();
    tick();
    check_empty("resume_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Execute-stage ALU with a registered 2-entry skid output buffer. It sits directly downstream of the ALU control decoder and consumes its 5-bit `alu_conf` and `sign` along with the ID/EX operands. Each accepted operation produces a result, a zero flag and a destination tag one cycle later, presented to the EX/MEM side over a valid/ready handshake. The input ready is registered, so upstream stall logic never sees a combinational path from the downstream ready.

## Interface
- `WIDTH`, 32: datapath width in bits.
- `clk  in  1`: clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `flush  in  1`: pipeline flush; drops all buffered entries.
- `in_valid  in  1`: upstream offers an operation.
- `in_ready  out  1`: stage can accept; registered.
- `alu_conf  in  5`: operation code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 sll, 7 srl, 8 sra, 9 slt; every other value is illegal (31 is the decoder default).
- `sign  in  1`: selects signed compare for slt; selects overflow checking for add/sub.
- `op_a  in  WIDTH`: rs operand.
- `op_b  in  WIDTH`: rt or immediate operand.
- `shamt  in  5`: shift amount.
- `rd_in  in  5`: destination register tag.
- `out_valid  out  1`: head entry is valid.
- `out_ready  in  1`: downstream accepts the head entry.
- `result  out  WIDTH`: head result.
- `zero  out  1`: head result equals 0.
- `rd_out  out  5`: head destination tag.
- `illegal  out  1`: head entry carried an illegal `alu_conf`.
- `ovf  out  1`: head entry overflowed (see Configuration).

## Operation
- The stage accepts an operation when `in_valid && in_ready`. It computes the result combinationally and writes it into the tail of the skid buffer.
- add and sub wrap modulo 2^WIDTH.
- and, or, xor and nor are bitwise.
- sll, srl and sra shift `op_b` by `shamt`. sra replicates `op_b[WIDTH-1]`.
- slt produces `{WIDTH-1 zeros, lt}`. `lt` is a signed compare when `sign` = 1 and an unsigned compare when `sign` = 0.
- An illegal `alu_conf` gives `result` = 0, `zero` = 1 and `illegal` = 1. The entry is still enqueued and delivered.
- Each entry holds {result, zero, rd, illegal, ovf}. The outputs always show the head entry. When the buffer is empty, the outputs are 0.
- The buffer has three states, and `in_ready` = (state != FULL):
  - EMPTY: accept → ONE.
  - ONE: accept without pop → FULL. Pop without accept → EMPTY. Accept and pop together → ONE, with the new entry becoming the head.
  - FULL: pop → ONE, with the second entry promoted to head. No accept is possible in this state.
- A pop is `out_valid && out_ready`.
- `flush` forces EMPTY at the next edge and overrides any simultaneous accept or pop. The operation offered in that cycle is dropped.

## Timing
- Latency: an operation accepted at edge N is visible on the outputs after edge N, provided the buffer was EMPTY, or was ONE with a pop at N.
- Throughput is one operation per cycle while `out_ready` = 1.
- `in_ready` changes only on clock edges and depends only on state.
- While `out_valid` = 1 and `out_ready` = 0, the outputs must stay stable.
- Reset (asynchronous, mid-operation included):
  - State goes to EMPTY immediately and all entries are cleared.
  - `out_valid`, `result`, `rd_out`, `illegal` and `ovf` are 0. `zero` is 0 while the buffer is empty.
  - `in_ready` is 1 once the state is EMPTY.
- The first accept is possible at the first rising edge after `rst_n` deasserts.

## Configuration
- `ALU_OVF_TRAP_EN` defined: a signed overflow (`sign` = 1) on add or sub sets `ovf` = 1 and forces `rd_out` = 0 for that entry, so the write-back is suppressed. `result` keeps the wrapped sum. `zero` still reflects `result`.
- `ALU_OVF_TRAP_EN` undefined: the `ovf` port is tied to 0 and `rd_out` always equals the captured `rd_in`.

## Test plan
- Reset, then a single add: `op_a` = 5, `op_b` = 7, `rd_in` = 3, `out_ready` = 1 → one cycle later `out_valid` = 1, `result` = 12, `rd_out` = 3, `zero` = 0.
- slt with `op_a` = 0xFFFFFFFF and `op_b` = 1 → `result` = 1 with `sign` = 1 and 0 with `sign` = 0. sra of 0x80000000 by 4 → 0xF8000000.
- Backpressure: `out_ready` = 0 while three back-to-back ops are offered → two are accepted, `in_ready` = 0 after the second, and the head holds stable. Raising `out_ready` drains both entries in order, then the third op is accepted.
- Illegal and flush:
  - `alu_conf` = 31 → `illegal` = 1, `result` = 0, `zero` = 1.
  - `flush` asserted while FULL and `in_valid` = 1 → next cycle `out_valid` = 0 and `in_ready` = 1, and the offered op is never delivered.
- Overflow: add 0x7FFFFFFF + 1 with `sign` = 1 and `rd_in` = 9 →
  - With `ALU_OVF_TRAP_EN`: `ovf` = 1, `rd_out` = 0, `result` = 0x80000000.
  - Without it: `ovf` = 0, `rd_out` = 9.
  - The same add with `sign` = 0 gives `ovf` = 0 in both builds.
- Asynchronous reset asserted mid-stream while FULL → `out_valid` drops to 0 without waiting for a clock edge, and the stream resumes cleanly after deassertion.
